// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the instruction fetch
// unit (IFU) and the load/store unit (LSU). Requests are granted round-robin,
// one transaction is outstanding at a time, and the tagged response is routed
// back to its owner. A watchdog abandons a stuck transaction and stray
// responses are flagged.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int BLOCK_W        = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_aH,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [ADDR_W-1:0]  ifu_req_addr,
  output logic               ifu_resp_valid,
  output logic [ADDR_W-1:0]  ifu_resp_addr,
  output logic [BLOCK_W-1:0] ifu_resp_data,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [ADDR_W-1:0]  lsu_req_addr,
  input  logic [2:0]         lsu_req_size,
  input  logic [WORD_W-1:0]  lsu_req_wdata,
  output logic               lsu_resp_valid,
  output logic [ADDR_W-1:0]  lsu_resp_addr,
  output logic [2:0]         lsu_resp_size,
  output logic [BLOCK_W-1:0] lsu_resp_data,
  output logic               mem_req_valid,
  output logic               mem_req_lsu_aL_ifu_aH,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [2:0]         mem_req_size,
  output logic [WORD_W-1:0]  mem_req_data,
  input  logic               mem_resp_valid,
  input  logic               mem_resp_lsu_aL_ifu_aH,
  input  logic [ADDR_W-1:0]  mem_resp_addr,
  input  logic [2:0]         mem_resp_size,
  input  logic [BLOCK_W-1:0] mem_resp_data,
  output logic               timeout_err,
  output logic               tag_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              prio;        // 1 = IFU has priority, 0 = LSU
  logic [CNT_W-1:0]  cnt;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              handshake;
  logic              resp_match;
  logic              timeout_hit;

  // Winner selection; readies only in IDLE and never while reset is held.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && !rst_aH) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = prio;
        grant_lsu = ~prio;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end else begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
      end
    end else begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  // The winner is by construction valid, so a grant is a completed handshake.
  assign handshake     = grant_ifu | grant_lsu;
  assign resp_match    = (state == WAIT) && mem_resp_valid &&
                         (mem_resp_lsu_aL_ifu_aH == mem_req_lsu_aL_ifu_aH);
  assign timeout_hit   = (state == WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state logic; a matching response beats the watchdog in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (handshake) state_nx = ISSUE;
        else           state_nx = IDLE;
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (resp_match)       state_nx = RESP;
        else if (timeout_hit) state_nx = IDLE;
        else                  state_nx = WAIT;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (handshake) prio <= grant_lsu;
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  // Request latch doubles as the memory request fields; strobe lasts one cycle.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      mem_req_valid         <= 1'b0;
      mem_req_lsu_aL_ifu_aH <= 1'b0;
      mem_req_addr          <= '0;
      mem_req_size          <= 3'b000;
      mem_req_data          <= '0;
    end else begin
      mem_req_valid <= handshake;
      if (grant_ifu) begin
        mem_req_lsu_aL_ifu_aH <= 1'b1;
        mem_req_addr          <= ifu_req_addr;
        mem_req_size          <= 3'b100;
        mem_req_data          <= '0;
      end else if (grant_lsu) begin
        mem_req_lsu_aL_ifu_aH <= 1'b0;
        mem_req_addr          <= lsu_req_addr;
        mem_req_size          <= lsu_req_size;
        mem_req_data          <= lsu_req_wdata;
      end
    end
  end

  // Capture the matching response into the owner's fields; strobe in RESP.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_addr  <= '0;
      ifu_resp_data  <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_addr  <= '0;
      lsu_resp_size  <= 3'b000;
      lsu_resp_data  <= '0;
    end else begin
      ifu_resp_valid <= resp_match & mem_req_lsu_aL_ifu_aH;
      lsu_resp_valid <= resp_match & ~mem_req_lsu_aL_ifu_aH;
      if (resp_match && mem_req_lsu_aL_ifu_aH) begin
        ifu_resp_addr <= mem_resp_addr;
        ifu_resp_data <= mem_resp_data;
      end
      if (resp_match && !mem_req_lsu_aL_ifu_aH) begin
        lsu_resp_addr <= mem_resp_addr;
        lsu_resp_size <= mem_resp_size;
        lsu_resp_data <= mem_resp_data;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      timeout_err <= 1'b0;
      tag_err     <= 1'b0;
    end else begin
      if (mem_resp_valid && !resp_match) tag_err <= 1'b1;
      if (timeout_hit && !resp_match)    timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory request/response port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts valid/ready requests from both requesters and grants them round-robin.
- Issues exactly one outstanding transaction to main memory.
- Routes the tagged response back to the owning requester, with a watchdog timeout and protocol-error detection.

Parameters:
- ADDR_W, 32, address width
- WORD_W, 32, LSU write-data width
- BLOCK_W, 64, response data width (icache block)
- TIMEOUT_CYCLES, 64, max WAIT cycles before a transaction is abandoned (≥2)

Ports:
- clk  in  1  clock
- rst_aH  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  IFU block-fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  IFU response strobe
- ifu_resp_addr  out  ADDR_W  echoed address
- ifu_resp_data  out  BLOCK_W  fetched block
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  access address
- lsu_req_size  in  3  access size, passed through unmodified
- lsu_req_wdata  in  WORD_W  store data
- lsu_resp_valid  out  1  LSU response strobe
- lsu_resp_addr  out  ADDR_W  echoed address
- lsu_resp_size  out  3  echoed size
- lsu_resp_data  out  BLOCK_W  response data
- mem_req_valid  out  1  one-cycle request strobe to main memory
- mem_req_lsu_aL_ifu_aH  out  1  tag: 1 = IFU, 0 = LSU
- mem_req_addr  out  ADDR_W  address
- mem_req_size  out  3  size; 3'b100 for IFU
- mem_req_data  out  WORD_W  store data; 0 for IFU
- mem_resp_valid  in  1  main-memory response strobe
- mem_resp_lsu_aL_ifu_aH  in  1  response tag
- mem_resp_addr  in  ADDR_W  response address
- mem_resp_size  in  3  response size
- mem_resp_data  in  BLOCK_W  response data
- timeout_err  out  1  sticky: transaction abandoned
- tag_err  out  1  sticky: unexpected or mismatched response

Behaviour:
- Reset (async, rst_aH=1):
  - state = IDLE; prio = LSU.
  - All outputs 0, including mem_req_*, *_resp_*, both err flags and the timeout counter.
  - An in-flight transaction is dropped. A response arriving after reset is treated as spurious.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - *_req_ready is combinational and asserted only for the winner. The handshake completes when valid & ready.
  - Winner selection:
    - Only one requester valid: that requester wins.
    - Both valid: the requester indicated by prio wins.
  - On handshake: latch addr/size/data/tag (IFU: size = 3'b100, data = 0); prio flips to the other requester; go to ISSUE.
  - No request: both ready = 0; prio unchanged.
- ISSUE:
  - mem_req_valid = 1 and mem_req_* driven from the latch for exactly one cycle; counter cleared.
  - Next state is WAIT.
  - mem_resp_valid in this cycle sets tag_err; the response is discarded.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid with tag equal to the latched tag: capture addr/size/data; go to RESP.
  - mem_resp_valid with mismatched tag: set tag_err, discard, stay in WAIT.
  - Counter reaching TIMEOUT_CYCLES with no matching response: set timeout_err; go to IDLE with no response to the requester.
  - A matching response in the same cycle as the timeout wins: go to RESP, no timeout_err.
- RESP:
  - Exactly one of ifu_resp_valid / lsu_resp_valid is 1 for one cycle, with captured fields. Next state is IDLE.
  - Response data fields hold their value between strobes; only the valid strobes pulse.
- mem_resp_valid in IDLE or RESP: set tag_err; response discarded.
- Both ready never asserted together. ready is 0 in every state other than IDLE.
- Latency (1-cycle main memory): handshake T, mem_req_valid T+1, mem_resp_valid T+2, *_resp_valid T+3, next handshake possible at T+4. Sustained throughput is one transaction per 4 cycles.
- Err flags are cleared only by reset.

Test Plan:
- IFU only, addr 0x100, mem responds tag 1 at T+2 with data 0xDEADBEEF_CAFEF00D -> mem_req_valid=1 at T+1 with size 3'b100 and data 0; ifu_resp_valid at T+3 with addr 0x100 and that data; lsu_resp_valid stays 0.
- IFU and LSU held valid continuously from reset -> grants alternate LSU, IFU, LSU, IFU; handshakes at cycles 0, 4, 8, 12; never two readys in one cycle.
- LSU store addr 0x40, size 3'b010, wdata 0x1234 -> mem_req carries tag 0, size 3'b010, data 0x1234; lsu_resp_size = 3'b010.
- No response after issue, TIMEOUT_CYCLES=64 -> timeout_err rises after 64 WAIT cycles; state returns to IDLE; a new IFU request is then accepted normally.
- Tag-1 response while an LSU transaction is outstanding -> tag_err=1; no resp strobe; the later tag-0 response completes to the LSU normally.
- rst_aH asserted during WAIT, response arrives after release -> all outputs 0 during reset; post-release response sets tag_err; no *_resp_valid.
